serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port i_start, input, 1 bit: request to begin one subtraction; sampled only in IDLE.
REQ-005 SHALL have port i_a, input, WIDTH bits: minuend; captured on an accepted start.
REQ-006 SHALL have port i_b, input, WIDTH bits: subtrahend; captured on an accepted start.
REQ-007 SHALL have port o_diff, output, WIDTH bits: registered result i_a - i_b, modulo 2^WIDTH.
REQ-008 SHALL have port o_borrow, output, 1 bit: final borrow out; 1 when i_a < i_b unsigned.
REQ-009 SHALL have port o_overflow, output, 1 bit: two's-complement signed overflow of the subtraction.
REQ-010 SHALL have port o_busy, output, 1 bit: high while bits are being processed (SHIFT state).
REQ-011 SHALL have port o_done, output, 1 bit: single-cycle pulse marking a valid new result.

Function
REQ-012 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-013 IDLE -> SHIFT on a rising edge with i_start=1; at that edge capture i_a and i_b into internal shift registers, clear the borrow flop to 0 and clear the bit counter to 0.
REQ-014 SHALL, in SHIFT, process exactly one bit per cycle, LSB first: diff_bit = a^b^borrow; next_borrow = (~a & b) | (~(a^b) & borrow).
REQ-015 SHALL shift each diff_bit into the result register from the MSB side, so that after WIDTH bits bit 0 holds the LSB.
REQ-016 SHALL remain in SHIFT for exactly WIDTH cycles; on the edge that processes bit WIDTH-1, go SHIFT -> DONE and update o_diff, o_borrow and o_overflow together.
REQ-017 o_overflow SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
REQ-018 SHALL leave DONE unconditionally after one cycle (DONE -> IDLE); o_done=1 only in DONE.
REQ-019 Latency: start accepted at edge k -> o_busy high from edge k to edge k+WIDTH; o_done high from edge k+WIDTH to edge k+WIDTH+1.
REQ-020 SHALL ignore i_start in SHIFT and DONE: no operand recapture and no restart.
REQ-021 SHALL ignore changes on i_a and i_b after capture.
REQ-022 SHALL hold o_diff, o_borrow and o_overflow stable from DONE until the next DONE.
REQ-023 Back-to-back: i_start held high SHALL produce a new acceptance on the first edge in IDLE after DONE, a period of WIDTH+2 cycles.
REQ-024 SHALL derive the bit counter width from WIDTH; the counter SHALL NOT wrap within one operation.

Reset
REQ-025 i_reset_n=0 SHALL immediately force state IDLE, o_diff=0, o_borrow=0, o_overflow=0, o_busy=0, o_done=0, and clear the counter, borrow flop and shift registers.
REQ-026 A reset asserted mid-operation SHALL abort the operation with no o_done pulse; the first edge after deassertion with i_start=1 SHALL begin a fresh operation.

Verification
REQ-027 Basic: WIDTH=8, i_a=0x50, i_b=0x20, 1-cycle start -> after 8 busy cycles, o_done pulse; o_diff=0x30, o_borrow=0, o_overflow=0.
REQ-028 Borrow: i_a=0x05, i_b=0x0A -> o_diff=0xFB, o_borrow=1, o_overflow=0.
REQ-029 Signed overflow: i_a=0x80, i_b=0x01 -> o_diff=0x7F, o_borrow=0, o_overflow=1; and i_a=0x7F, i_b=0xFF -> o_diff=0x80, o_borrow=1, o_overflow=1.
REQ-030 Busy protection: start 0x10-0x01, then pulse i_start with i_a=0xFF, i_b=0x00 at busy cycle 3 -> result 0x0F, exactly one o_done pulse.
REQ-031 Reset mid-op: assert i_reset_n=0 at busy cycle 4 -> all outputs 0 immediately, no o_done; a following start 0x09-0x09 -> o_diff=0x00, o_borrow=0.
REQ-032 Random: 1000 random operand pairs with i_start held high -> each result matches the reference model, with a done period of exactly 10 cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned/two's-complement subtractor: one bit per clock, LSB first,
// with registered difference, borrow-out and signed-overflow results.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_overflow,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic             borrow_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_out_reg;
    logic             overflow_reg;

    logic             diff_bit;
    logic             borrow_next;
    logic             last_bit;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        diff_bit    = a_sr_reg[0] ^ b_sr_reg[0] ^ borrow_reg;
        borrow_next = (~a_sr_reg[0] & b_sr_reg[0]) | (~(a_sr_reg[0] ^ b_sr_reg[0]) & borrow_reg);
        last_bit    = (cnt_reg == CNT_W'(WIDTH - 1));
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                o_busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The minuend register doubles as the result shift register: each consumed
    // LSB is replaced by a difference bit entering from the MSB side.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_reg        <= '0;
            a_sr_reg       <= '0;
            b_sr_reg       <= '0;
            borrow_reg     <= 1'b0;
            diff_reg       <= '0;
            borrow_out_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        a_sr_reg   <= i_a;
                        b_sr_reg   <= i_b;
                        borrow_reg <= 1'b0;
                        cnt_reg    <= '0;
                    end
                end
                SHIFT: begin
                    a_sr_reg   <= {diff_bit, a_sr_reg[WIDTH-1:1]};
                    b_sr_reg   <= {1'b0, b_sr_reg[WIDTH-1:1]};
                    borrow_reg <= borrow_next;
                    if (last_bit) begin
                        // On the final bit, a_sr_reg[0]/b_sr_reg[0] are the operand sign bits.
                        diff_reg       <= {diff_bit, a_sr_reg[WIDTH-1:1]};
                        borrow_out_reg <= borrow_next;
                        overflow_reg   <= (a_sr_reg[0] != b_sr_reg[0]) && (diff_bit != a_sr_reg[0]);
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_diff     = diff_reg;
    assign o_borrow   = borrow_out_reg;
    assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases, busy/reset
// protection and a long randomized back-to-back run against an arithmetic model.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_start    (start),
        .i_a        (a),
        .i_b        (b),
        .o_diff     (diff),
        .o_borrow   (borrow),
        .o_overflow (overflow),
        .o_busy     (busy),
        .o_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic ref_model(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                             output logic [WIDTH-1:0] rdiff, output logic rborrow,
                             output logic rovf);
        int ua, ub, sa, sb, sres;
        ua = int'(ra);
        ub = int'(rb);
        sa = (ua >= (1 << (WIDTH - 1))) ? ua - (1 << WIDTH) : ua;
        sb = (ub >= (1 << (WIDTH - 1))) ? ub - (1 << WIDTH) : ub;
        sres    = sa - sb;
        rdiff   = WIDTH'((ua - ub + (1 << WIDTH)) % (1 << WIDTH));
        rborrow = (ua < ub);
        rovf    = (sres > (1 << (WIDTH - 1)) - 1) || (sres < -(1 << (WIDTH - 1)));
    endtask

    // One operation with a 1-cycle start; optionally pulse i_start with other
    // operands at busy cycle pulse_at (1-based, 0 = none).
    task automatic do_op(input string name, input logic [WIDTH-1:0] ta,
                         input logic [WIDTH-1:0] tb, input int pulse_at);
        logic [WIDTH-1:0] e_diff;
        logic             e_borrow, e_ovf;
        int busy_cnt, done_cnt, done_at;
        ref_model(ta, tb, e_diff, e_borrow, e_ovf);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb;
        @(negedge clk);
        start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom);
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int c = 0; c < WIDTH + 4; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = c;
                check({name, "_diff"},     32'(diff),     32'(e_diff));
                check({name, "_borrow"},   32'(borrow),   32'(e_borrow));
                check({name, "_overflow"}, 32'(overflow), 32'(e_ovf));
            end
            if (pulse_at != 0 && c == pulse_at - 1) begin
                start = 1'b1; a = '1; b = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
        check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({name, "_done_latency"}, 32'(done_at), 32'(WIDTH));
        check({name, "_diff_held"}, 32'(diff), 32'(e_diff));
        $display("op %s: a=0x%02h b=0x%02h diff=0x%02h borrow=%0b ovf=%0b busy=%0d done=%0d",
                 name, ta, tb, diff, borrow, overflow, busy_cnt, done_cnt);
    endtask

    logic [WIDTH-1:0] q_a[$];
    logic [WIDTH-1:0] q_b[$];

    initial begin
        logic [WIDTH-1:0] ra, rb, e_diff;
        logic             e_borrow, e_ovf;
        int               n_done, last_done, guard, done_cnt;

        reset_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #1;
        check("reset_diff",     32'(diff),     32'd0);
        check("reset_borrow",   32'(borrow),   32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_busy",     32'(busy),     32'd0);
        check("reset_done",     32'(done),     32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        do_op("basic",  8'h50, 8'h20, 0);
        do_op("borrow", 8'h05, 8'h0A, 0);
        do_op("ovf_a",  8'h80, 8'h01, 0);
        do_op("ovf_b",  8'h7F, 8'hFF, 0);
        do_op("busy_protect", 8'h10, 8'h01, 3);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_borrow", 32'(borrow), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < WIDTH + 2; c++) begin
            @(negedge clk);
            if (c == 1) reset_n = 1'b1;
            if (done) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        $display("op midrst: reset applied at busy cycle 4, done pulses=%0d", done_cnt);
        do_op("after_rst", 8'h09, 8'h09, 0);

        // Randomized back-to-back run with i_start held high.
        @(negedge clk);
        ra = WIDTH'($urandom); rb = WIDTH'($urandom);
        q_a.push_back(ra); q_b.push_back(rb);
        a = ra; b = rb; start = 1'b1;
        n_done = 0; last_done = -1; guard = 0;
        while (n_done < 1000) begin
            @(negedge clk);
            guard++;
            if (guard > 3 * (WIDTH + 2)) begin
                check("rand_timeout", 32'(n_done), 32'd1000);
                break;
            end
            if (done) begin
                guard = 0;
                ra = q_a.pop_front();
                rb = q_b.pop_front();
                ref_model(ra, rb, e_diff, e_borrow, e_ovf);
                check("rand_diff",     32'(diff),     32'(e_diff));
                check("rand_borrow",   32'(borrow),   32'(e_borrow));
                check("rand_overflow", 32'(overflow), 32'(e_ovf));
                if (last_done >= 0) check("rand_period", 32'(cyc - last_done), 32'(WIDTH + 2));
                $display("rand %0d: a=0x%02h b=0x%02h diff=0x%02h borrow=%0b ovf=%0b",
                         n_done, ra, rb, diff, borrow, overflow);
                last_done = cyc;
                n_done++;
                if (n_done < 1000) begin
                    ra = WIDTH'($urandom); rb = WIDTH'($urandom);
                    q_a.push_back(ra); q_b.push_back(rb);
                    a = ra; b = rb;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
